fp_addsub_sched: RTL

Round-robin scheduler that shares one fixed-latency floating-point add/sub unit between `NREQ` requesters. It arbitrates operand requests, issues them to the unit, and tracks in-flight ops with a tag pipeline. Results and error codes return to the originating requester, and per-requester sticky exception flags are accumulated. It sits between the issue stages and the add/sub datapath, whose final stage emits the packed result and an `o_err_t` error code.

---
 rtl/fp_addsub_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one fixed-latency FP add/sub unit; optional sticky flags under FP_STICKY_FLAGS_EN.
// Latency: issue 1 cycle after handshake, response LAT+1 cycles after issue (LAT+2 edges after handshake).
// Backpressure: req_ready grants one requester per cycle, none while draining; responses cannot be stalled.
module fp_addsub_sched #(
    parameter int  NREQ     = 2,
    parameter int  LAT      = 4,
    parameter int  EXP_BITS = 8,
    parameter int  SIG_BITS = 23,
    localparam int W        = 1 + EXP_BITS + SIG_BITS,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic              unit_valid_o,
    output logic [W-1:0]      unit_a_o,
    output logic [W-1:0]      unit_b_o,
    output logic              unit_sub_o,
    input  logic              unit_valid_i,
    input  logic [W-1:0]      unit_result_i,
    input  logic [2:0]        unit_err_i,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [2:0]        rsp_err,
    input  logic              flush_req,
    output logic              flush_done,
    input  logic [NREQ-1:0]   flag_clr,
    output logic [3*NREQ-1:0] flags,
    output logic              proto_err
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            flush_done_q, flush_done_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    int              cand;
    logic            iss_vld_q, iss_sub_q;
    logic [W-1:0]    iss_a_q, iss_b_q;
    logic [IDW-1:0]  iss_id_q;
    logic [LAT-1:0]  tag_vld_q;
    logic [IDW-1:0]  tag_id_q [LAT];
    logic [CW-1:0]   ign_q;
    logic            tail_vld, rsp_fire, mismatch, pipe_empty;
    logic [IDW-1:0]  tail_id;
    logic [NREQ-1:0] rsp_vld_q;
    logic [W-1:0]    rsp_dat_q;
    logic [2:0]      rsp_err_q;
    logic            proto_err_q;

    // First valid requester at or after the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = 0;
        if (state_q == RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(ptr_q) + k) % NREQ;
                if (!gnt_vld && req_valid[IDW'(cand)]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(cand);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end

    assign pipe_empty = !iss_vld_q && (tag_vld_q == '0);

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            DRAIN:   if (pipe_empty) begin
                         state_d      = RUN;
                         flush_done_d = 1'b1;
                     end
            default: state_d = RUN;
        endcase
    end

    assign tail_vld = tag_vld_q[LAT-1];
    assign tail_id  = tag_id_q[LAT-1];
    assign rsp_fire = tail_vld && unit_valid_i;
    // Strobes with an empty tail are tolerated for LAT cycles after reset: results of discarded ops.
    assign mismatch = tail_vld ? !unit_valid_i : (unit_valid_i && (ign_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
            ptr_q        <= '0;
            iss_vld_q    <= 1'b0;
            iss_sub_q    <= 1'b0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_id_q     <= '0;
            tag_vld_q    <= '0;
            for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
            ign_q        <= CW'(LAT);
            rsp_vld_q    <= '0;
            rsp_dat_q    <= '0;
            rsp_err_q    <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            ptr_q        <= ptr_d;
            iss_vld_q    <= gnt_vld;
            if (gnt_vld) begin
                iss_a_q   <= req_a[int'(gnt_id)*W +: W];
                iss_b_q   <= req_b[int'(gnt_id)*W +: W];
                iss_sub_q <= req_sub[gnt_id];
                iss_id_q  <= gnt_id;
            end
            tag_vld_q[0] <= iss_vld_q;
            tag_id_q[0]  <= iss_id_q;
            for (int k = 1; k < LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            if (ign_q != '0) ign_q <= ign_q - CW'(1);
            rsp_vld_q <= '0;
            if (rsp_fire) begin
                rsp_vld_q[tail_id] <= 1'b1;
                rsp_dat_q          <= unit_result_i;
                rsp_err_q          <= unit_err_i;
            end
            if (mismatch) proto_err_q <= 1'b1;
        end
    end

`ifdef FP_STICKY_FLAGS_EN
    logic [3*NREQ-1:0] flags_q, flags_d;
    logic [2:0]        flag_set;

    always_comb begin
        flag_set = 3'b000;
        case (unit_err_i)
            3'd1:    flag_set = 3'b001;
            3'd3:    flag_set = 3'b010;
            3'd4:    flag_set = 3'b100;
            default: flag_set = 3'b000;
        endcase
        flags_d = flags_q;
        for (int i = 0; i < NREQ; i++) begin
            if (flag_clr[i]) flags_d[3*i +: 3] = 3'b000;
        end
        // Applied after the clear so a same-cycle set survives it.
        if (rsp_fire) flags_d[3*int'(tail_id) +: 3] = flags_d[3*int'(tail_id) +: 3] | flag_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = ^flag_clr;
    assign flags           = '0;
`endif

    assign unit_valid_o = iss_vld_q;
    assign unit_a_o     = iss_a_q;
    assign unit_b_o     = iss_b_q;
    assign unit_sub_o   = iss_sub_q;
    assign rsp_valid    = rsp_vld_q;
    assign rsp_data     = rsp_dat_q;
    assign rsp_err      = rsp_err_q;
    assign flush_done   = flush_done_q;
    assign proto_err    = proto_err_q;
endmodule
